pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined add/subtract unit that generalises the fixed 32-bit, four-chunk ripple adder. The carry chain is split into CHUNK-bit slices, with one slice evaluated per pipeline stage and the carry registered between stages. It accepts one operation per cycle under a valid/ready handshake, supports add and subtract with signed overflow detection, and sits between operand-issue logic and the writeback path of the lab datapath.

## Interface
- WIDTH, 32: operand width; must be a multiple of CHUNK
- CHUNK, 8: slice width evaluated per pipeline stage
- STAGES = WIDTH/CHUNK: derived localparam, not overridable

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous, active-low
- in_valid  input  1  operand beat present
- in_ready  output  1  unit can accept a beat this cycle
- in1  input  [0:WIDTH-1]  operand A; bit 0 is MSB
- in2  input  [0:WIDTH-1]  operand B; bit 0 is MSB
- cin  input  1  carry-in; used only when sub=0
- sub  input  1  0: A+B+cin; 1: A−B (A + ~B + 1; cin ignored)
- out_valid  output  1  result beat present
- out_ready  input  1  consumer accepts the result this cycle
- out  output  [0:WIDTH-1]  sum/difference; bit 0 is MSB
- cout  output  1  carry out of bit 0; for sub=1, 1 means no borrow
- ovf  output  1  two's-complement signed overflow

## Operation
- Slice k (k=0..STAGES-1) covers bits [WIDTH-CHUNK*(k+1) : WIDTH-1-CHUNK*k]. Slice 0 is the LSB slice.
- Stage k computes slice k from the delayed operand slices and the registered carry of stage k−1. Stage 0 uses the effective carry-in: cin when sub=0, 1 when sub=1.
- When sub=1, in2 is inverted at capture. The inverted value is carried through the skew registers.
- Operand slices not yet consumed travel down a skew register chain. Finished result slices travel forward alongside them. Each stage holds a valid bit.
- The last stage produces:
  - cout = carry out of the MSB slice.
  - ovf = carry into bit 0 XOR carry out of bit 0.
- Flow control is a global stall. The pipeline advances when `!(out_valid && !out_ready)`, and in_ready equals that advance term.
  - Input handshake: in_valid && in_ready.
  - Output handshake: out_valid && out_ready.
  - When stalled, every stage register holds, including valid bits. Bubbles are not compressed.
- Bubbles: when in_valid=0 and the pipeline advances, a 0 valid bit enters stage 0.
- Carries are strictly per-beat. No carry or data leaks between consecutive beats.
- Results are exact modulo 2^WIDTH.

## Timing
- Reset: when rst_n=0 at a clock edge, all valid bits clear.
  - Outputs after reset: out_valid=0, out=0, cout=0, ovf=0, in_ready=1.
  - Reset mid-operation discards every in-flight beat. No partial result ever emerges.
- Latency: a beat accepted at edge t appears with out_valid=1 after edge t+STAGES, given no stall.
- Throughput: one beat per cycle while out_ready=1.
- out, cout and ovf are registered outputs. They are stable and held while out_valid=1 && out_ready=0.
- Simultaneous accept and release: with a full pipeline and out_ready=1, in_ready=1. The new beat enters while the oldest beat leaves in the same cycle.
- When out_valid=0, in_ready=1 regardless of out_ready. A pipeline with an empty head never blocks.
- Parameters STAGES=1 (CHUNK=WIDTH) must be legal: the unit degenerates to a single registered adder with the same handshake.

## Test plan
- Reset and latency: hold rst_n=0 for 2 cycles, then send one beat in1=0x0000_00FF, in2=0x0000_0001, cin=0, sub=0.
  - All outputs are 0 during reset.
  - out=0x0000_0100, cout=0, ovf=0 with out_valid high exactly 4 cycles after accept.
- Full carry ripple: in1=0xFFFF_FFFF, in2=0x0000_0000, cin=1 → out=0x0000_0000, cout=1, ovf=0.
  - Then send in1=0x7FFF_FFFF, in2=0x0000_0001 → out=0x8000_0000, ovf=1, cout=0.
- Subtract: in1=5, in2=7, sub=1, cin=1 (must be ignored) → out=0xFFFF_FFFE, cout=0.
  - Then in1=0x8000_0000, in2=1, sub=1 → out=0x7FFF_FFFF, ovf=1, cout=1.
- Back-to-back stream: 100 random beats with out_ready=1, alternating add and sub.
  - Results arrive in order, one per cycle, and match a reference model.
  - Consecutive beats with opposite carries do not cross-contaminate.
- Backpressure: random out_ready at 50% with in_valid held high.
  - No beat is lost or duplicated.
  - out is stable while stalled.
  - in_ready equals `!(out_valid && !out_ready)` every cycle.
- Mid-flight reset and parameters: assert rst_n=0 for one cycle with 3 beats in flight → no out_valid afterwards until a new beat is sent.
  - Rerun the stream test at WIDTH=16, CHUNK=4 and at WIDTH=8, CHUNK=8.

Source files
------------

// File: rtl/pipelined_adder_if.sv
// Operand-issue / writeback handshake bundle for the pipelined add/subtract unit.
// Vectors are [0:WIDTH-1], so bit 0 is the MSB.
interface pipelined_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] in1;
  logic [0:WIDTH-1] in2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [0:WIDTH-1] out;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, in1, in2, cin, sub, out_ready,
    input  in_ready, out_valid, out, cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin, sub, out_ready,
    output in_ready, out_valid, out, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: a capture rank followed by one CHUNK-bit carry slice per stage,
// with the carry registered between stages and a global stall on output backpressure.
module pipelined_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_adder_if.slave   bus
);
  localparam int STAGES = WIDTH / CHUNK;

  // Rank 0 is the capture register; rank k+1 holds the beat after slice k has been added.
  logic [0:WIDTH-1] a_q   [0:STAGES-1];
  logic [0:WIDTH-1] b_q   [0:STAGES-1];
  logic [0:WIDTH-1] r_q   [0:STAGES];
  logic             c_q   [0:STAGES];
  logic             v_q   [0:STAGES];
  logic [CHUNK:0]   sum_c [0:STAGES-1];
  logic             ovf_q;
  logic             advance;
  logic             c_msb;
  logic             ovf_n;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_c[k] = {1'b0, a_q[k][WIDTH-CHUNK*(k+1) +: CHUNK]}
               + {1'b0, b_q[k][WIDTH-CHUNK*(k+1) +: CHUNK]}
               + {{CHUNK{1'b0}}, c_q[k]};
    end
  end

  // Carry into the MSB is recovered from the MSB sum bit and its operand bits.
  assign c_msb   = sum_c[STAGES-1][CHUNK-1] ^ a_q[STAGES-1][0] ^ b_q[STAGES-1][0];
  assign ovf_n   = c_msb ^ sum_c[STAGES-1][CHUNK];
  assign advance = !(v_q[STAGES] && !bus.out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k <= STAGES; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        r_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      // Bubbles carry zero data so idle ranks never show stale operands.
      v_q[0] <= bus.in_valid;
      a_q[0] <= bus.in_valid ? bus.in1 : '0;
      b_q[0] <= bus.in_valid ? (bus.sub ? ~bus.in2 : bus.in2) : '0;
      c_q[0] <= bus.in_valid & (bus.sub | bus.cin);
      r_q[0] <= '0;
      for (int k = 0; k < STAGES; k++) begin
        v_q[k+1] <= v_q[k];
        c_q[k+1] <= sum_c[k][CHUNK];
        r_q[k+1] <= r_q[k];
        r_q[k+1][WIDTH-CHUNK*(k+1) +: CHUNK] <= sum_c[k][CHUNK-1:0];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k+1] <= a_q[k];
        b_q[k+1] <= b_q[k];
      end
      ovf_q <= ovf_n;
    end
  end

  assign bus.in_ready  = advance;
  assign bus.out_valid = v_q[STAGES];
  assign bus.out       = r_q[STAGES];
  assign bus.cout      = c_q[STAGES];
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: 32/8 main instance plus 16/4 and 8/8 instances.
module tb_pipelined_adder;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  typedef struct {
    logic [31:0] out;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q32[$];
  exp_t q16[$];
  exp_t q8[$];

  pipelined_adder_if #(.WIDTH(32)) bus32 ();
  pipelined_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_adder_if #(.WIDTH(8))  bus8 ();

  pipelined_adder #(.WIDTH(32), .CHUNK(8)) u32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  pipelined_adder #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  pipelined_adder #(.WIDTH(8),  .CHUNK(8)) u8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
    $fatal(1);
  end

  // Independent reference: full-width sum with mask, overflow from operand/result signs.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic sb, input int w);
    logic [32:0] mask;
    logic [32:0] full;
    logic [31:0] am;
    logic [31:0] be;
    exp_t        e;
    mask   = (33'd1 << w) - 33'd1;
    am     = a & mask[31:0];
    be     = (sb ? ~b : b) & mask[31:0];
    full   = {1'b0, am} + {1'b0, be} + {32'd0, (sb | ci)};
    e.out  = full[31:0] & mask[31:0];
    e.cout = full[w];
    e.ovf  = (am[w-1] == be[w-1]) && (e.out[w-1] != am[w-1]);
    return e;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      vectors++;
      if (bus32.out_valid !== 1'b0 || bus32.out !== 32'd0 || bus32.cout !== 1'b0 ||
          bus32.ovf !== 1'b0 || bus32.in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_outputs: got valid=%b out=%h cout=%b ovf=%b rdy=%b, expected 0 0 0 0 1",
                 bus32.out_valid, bus32.out, bus32.cout, bus32.ovf, bus32.in_ready);
      end
    end
    rst_n = 1'b1;
    bus32.in_valid = 1'b1;
    bus32.in1 = 32'h0000_00FF;
    bus32.in2 = 32'h0000_0001;
    bus32.cin = 1'b0;
    bus32.sub = 1'b0;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    bus32.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (i < 4) begin
        if (bus32.out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL latency_early: cycle %0d got out_valid=%b expected 0", i, bus32.out_valid);
        end
      end else if (bus32.out_valid !== 1'b1 || bus32.out !== 32'h0000_0100 ||
                   bus32.cout !== 1'b0 || bus32.ovf !== 1'b0) begin
        miscompares++;
        $display("FAIL latency_result: got valid=%b out=%h cout=%b ovf=%b, expected 1 00000100 0 0",
                 bus32.out_valid, bus32.out, bus32.cout, bus32.ovf);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (bus32.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_drain: got out_valid=%b expected 0", bus32.out_valid);
    end
  endtask

  task automatic test_carry_sub();
    logic [31:0] ta[4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0005, 32'h8000_0000};
    logic [31:0] tb[4] = '{32'h0000_0000, 32'h0000_0001, 32'h0000_0007, 32'h0000_0001};
    logic        tc[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic        ts[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] eo[4] = '{32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
    logic        ec[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic        ev[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    exp_t e;
    int   sent = 0;
    int   got = 0;
    bus32.out_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (sent < 4) begin
        bus32.in_valid = 1'b1;
        bus32.in1 = ta[sent];
        bus32.in2 = tb[sent];
        bus32.cin = tc[sent];
        bus32.sub = ts[sent];
      end else bus32.in_valid = 1'b0;
      @(negedge clk);
      if (bus32.out_valid && bus32.out_ready) begin
        vectors++;
        if (q32.size() == 0) begin
          miscompares++;
          $display("FAIL carry_sub_extra: got out=%h with no beat expected", bus32.out);
        end else begin
          e = q32.pop_front();
          if (bus32.out !== e.out || bus32.cout !== e.cout || bus32.ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL carry_sub beat %0d: got out=%h cout=%b ovf=%b, expected out=%h cout=%b ovf=%b",
                     got, bus32.out, bus32.cout, bus32.ovf, e.out, e.cout, e.ovf);
          end
        end
        got++;
      end
      if (bus32.in_valid && bus32.in_ready) begin
        e.out = eo[sent]; e.cout = ec[sent]; e.ovf = ev[sent];
        q32.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (got != 4) begin
      miscompares++;
      $display("FAIL carry_sub_timeout: got %0d results, expected 4", got);
    end
    q32.delete();
  endtask

  task automatic test_back_to_back();
    logic [31:0] fa[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    logic [31:0] fb[4] = '{32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001};
    logic [31:0] a, b;
    logic        ci, sb;
    exp_t e;
    int   sent = 0;
    int   got = 0;
    int   first_cyc = -1;
    int   last_cyc = -1;
    bus32.out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && got < 100; cyc++) begin
      if (sent < 100) begin
        sb = sent[0];
        a  = (sent < 4) ? fa[sent] : $urandom();
        b  = (sent < 4) ? fb[sent] : $urandom();
        ci = (sent < 4) ? 1'b0 : 1'($urandom_range(0, 1));
        bus32.in_valid = 1'b1;
        bus32.in1 = a; bus32.in2 = b; bus32.cin = ci; bus32.sub = sb;
      end else bus32.in_valid = 1'b0;
      @(negedge clk);
      if (bus32.out_valid && bus32.out_ready) begin
        vectors++;
        if (q32.size() == 0) begin
          miscompares++;
          $display("FAIL stream_extra: got out=%h with no beat expected", bus32.out);
        end else begin
          e = q32.pop_front();
          if (bus32.out !== e.out || bus32.cout !== e.cout || bus32.ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL stream beat %0d: got out=%h cout=%b ovf=%b, expected out=%h cout=%b ovf=%b",
                     got, bus32.out, bus32.cout, bus32.ovf, e.out, e.cout, e.ovf);
          end
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      if (bus32.in_valid && bus32.in_ready) begin
        q32.push_back(model(a, b, ci, sb, 32));
        sent++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (got != 100 || last_cyc - first_cyc != 99) begin
      miscompares++;
      $display("FAIL stream_rate: got %0d results over %0d cycles, expected 100 over 100",
               got, last_cyc - first_cyc + 1);
    end
    q32.delete();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, prev_out;
    logic        ci, sb, prev_cout, prev_ovf, exp_rdy;
    logic        prev_stall = 1'b0;
    logic        need_new = 1'b1;
    exp_t e;
    int   sent = 0;
    int   got = 0;
    for (int cyc = 0; cyc < 800 && got < 60; cyc++) begin
      bus32.out_ready = 1'($urandom_range(0, 1));
      if (sent < 60) begin
        if (need_new) begin
          a = $urandom(); b = $urandom();
          ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
          need_new = 1'b0;
        end
        bus32.in_valid = 1'b1;
        bus32.in1 = a; bus32.in2 = b; bus32.cin = ci; bus32.sub = sb;
      end else bus32.in_valid = 1'b0;
      @(negedge clk);
      exp_rdy = !(bus32.out_valid && !bus32.out_ready);
      vectors++;
      if (bus32.in_ready !== exp_rdy) begin
        miscompares++;
        $display("FAIL bp_in_ready cycle %0d: got %b expected %b", cyc, bus32.in_ready, exp_rdy);
      end
      if (prev_stall) begin
        vectors++;
        if (bus32.out_valid !== 1'b1 || bus32.out !== prev_out ||
            bus32.cout !== prev_cout || bus32.ovf !== prev_ovf) begin
          miscompares++;
          $display("FAIL bp_hold cycle %0d: got valid=%b out=%h cout=%b ovf=%b, expected 1 %h %b %b",
                   cyc, bus32.out_valid, bus32.out, bus32.cout, bus32.ovf, prev_out, prev_cout, prev_ovf);
        end
      end
      if (bus32.out_valid && bus32.out_ready) begin
        vectors++;
        if (q32.size() == 0) begin
          miscompares++;
          $display("FAIL bp_extra: got out=%h with no beat expected", bus32.out);
        end else begin
          e = q32.pop_front();
          if (bus32.out !== e.out || bus32.cout !== e.cout || bus32.ovf !== e.ovf) begin
            miscompares++;
            $display("FAIL bp beat %0d: got out=%h cout=%b ovf=%b, expected out=%h cout=%b ovf=%b",
                     got, bus32.out, bus32.cout, bus32.ovf, e.out, e.cout, e.ovf);
          end
        end
        got++;
      end
      if (bus32.in_valid && bus32.in_ready) begin
        q32.push_back(model(a, b, ci, sb, 32));
        sent++;
        need_new = 1'b1;
      end
      prev_stall = bus32.out_valid && !bus32.out_ready;
      prev_out = bus32.out; prev_cout = bus32.cout; prev_ovf = bus32.ovf;
      @(posedge clk); #1;
    end
    vectors++;
    if (got != 60 || q32.size() != 0) begin
      miscompares++;
      $display("FAIL bp_count: got %0d results with %0d pending, expected 60 with 0 pending",
               got, q32.size());
    end
    q32.delete();
  endtask

  task automatic test_midflight_reset();
    exp_t e;
    int   got = 0;
    bus32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus32.in_valid = 1'b1;
      bus32.in1 = 32'h1000_0000 + 32'(i);
      bus32.in2 = 32'hF000_0000;
      bus32.cin = 1'b1;
      bus32.sub = 1'b0;
      @(posedge clk); #1;
    end
    bus32.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if (bus32.out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL midreset_leak cycle %0d: got out_valid=%b out=%h expected 0", i, bus32.out_valid, bus32.out);
      end
      @(posedge clk); #1;
    end
    bus32.in_valid = 1'b1;
    bus32.in1 = 32'h1234_5678;
    bus32.in2 = 32'h1111_1111;
    bus32.cin = 1'b0;
    bus32.sub = 1'b0;
    @(posedge clk); #1;
    bus32.in_valid = 1'b0;
    for (int cyc = 0; cyc < 20 && got < 1; cyc++) begin
      @(negedge clk);
      if (bus32.out_valid) begin
        vectors++;
        if (bus32.out !== 32'h2345_6789 || bus32.cout !== 1'b0 || bus32.ovf !== 1'b0) begin
          miscompares++;
          $display("FAIL midreset_next: got out=%h cout=%b ovf=%b, expected 23456789 0 0",
                   bus32.out, bus32.cout, bus32.ovf);
        end
        got++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (got != 1) begin
      miscompares++;
      $display("FAIL midreset_timeout: got %0d results, expected 1", got);
    end
  endtask

  task automatic test_small_params();
    logic [31:0] a, b;
    logic        ci, sb;
    exp_t e;
    int   sent16 = 0, sent8 = 0, got16 = 0, got8 = 0;
    bus16.out_ready = 1'b1;
    bus8.out_ready  = 1'b1;
    for (int cyc = 0; cyc < 200 && (got16 < 50 || got8 < 50); cyc++) begin
      a = $urandom(); b = $urandom();
      ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      bus16.in_valid = (sent16 < 50);
      bus8.in_valid  = (sent8 < 50);
      bus16.in1 = a[15:0]; bus16.in2 = b[15:0]; bus16.cin = ci; bus16.sub = sb;
      bus8.in1  = a[7:0];  bus8.in2  = b[7:0];  bus8.cin  = ci; bus8.sub  = sb;
      @(negedge clk);
      if (bus16.out_valid) begin
        vectors++;
        e = (q16.size() != 0) ? q16.pop_front() : '{32'hDEAD_BEEF, 1'bx, 1'bx};
        if ({16'd0, bus16.out} !== e.out || bus16.cout !== e.cout || bus16.ovf !== e.ovf) begin
          miscompares++;
          $display("FAIL w16 beat %0d: got out=%h cout=%b ovf=%b, expected out=%h cout=%b ovf=%b",
                   got16, bus16.out, bus16.cout, bus16.ovf, e.out, e.cout, e.ovf);
        end
        got16++;
      end
      if (bus8.out_valid) begin
        vectors++;
        e = (q8.size() != 0) ? q8.pop_front() : '{32'hDEAD_BEEF, 1'bx, 1'bx};
        if ({24'd0, bus8.out} !== e.out || bus8.cout !== e.cout || bus8.ovf !== e.ovf) begin
          miscompares++;
          $display("FAIL w8 beat %0d: got out=%h cout=%b ovf=%b, expected out=%h cout=%b ovf=%b",
                   got8, bus8.out, bus8.cout, bus8.ovf, e.out, e.cout, e.ovf);
        end
        got8++;
      end
      if (bus16.in_valid && bus16.in_ready) begin
        q16.push_back(model(a, b, ci, sb, 16));
        sent16++;
      end
      if (bus8.in_valid && bus8.in_ready) begin
        q8.push_back(model(a, b, ci, sb, 8));
        sent8++;
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (got16 != 50 || got8 != 50) begin
      miscompares++;
      $display("FAIL small_count: got w16=%0d w8=%0d results, expected 50 and 50", got16, got8);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus32.in_valid = 1'b0; bus32.in1 = '0; bus32.in2 = '0; bus32.cin = 1'b0; bus32.sub = 1'b0;
    bus32.out_ready = 1'b0;
    bus16.in_valid = 1'b0; bus16.in1 = '0; bus16.in2 = '0; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.out_ready = 1'b1;
    bus8.in_valid = 1'b0;  bus8.in1 = '0;  bus8.in2 = '0;  bus8.cin = 1'b0;  bus8.sub = 1'b0;
    bus8.out_ready = 1'b1;
    test_reset();
    test_carry_sub();
    test_back_to_back();
    test_backpressure();
    test_midflight_reset();
    test_small_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
